// File: rtl/tour_move_sched_if.sv
// tour_move_sched_if: tour_logic, UART_wrapper and cmd_proc signals seen by the move scheduler
interface tour_move_sched_if #(
  parameter int IDX_W = 5
);
  logic             start_tour;
  logic [7:0]       move;
  logic [IDX_W-1:0] mv_indx;
  logic [15:0]      cmd_UART;
  logic             cmd_rdy_UART;
  logic             clr_cmd_rdy;
  logic             send_resp;
  logic [15:0]      cmd;
  logic             cmd_rdy;
  logic             clr_UART_rdy;
  logic [7:0]       resp;
  logic             tour_err;
  modport slave (
    input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output mv_indx, cmd, cmd_rdy, clr_UART_rdy, resp, tour_err
  );
  modport master (
    output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  mv_indx, cmd, cmd_rdy, clr_UART_rdy, resp, tour_err
  );
endinterface

// File: rtl/tour_move_sched.sv
// tour_move_sched: replays a solved knight's tour as vertical/horizontal cmd_proc legs and muxes the UART command path
module tour_move_sched #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input logic              clk,
  input logic              rst,
  tour_move_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE, VERT, HOLD_V, HORZ, HOLD_H} state_t;
  state_t           r_state, w_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             w_valid, w_last, w_idle, w_start, w_inc;
  logic             w_up, w_dy2, w_right, w_dx2;
  logic [15:0]      w_vert, w_horz;
  assign w_valid = $onehot(bus.move);
  assign w_last  = r_idx == IDX_W'(NUM_MOVES - 1);
  assign w_idle  = r_state == IDLE;
  // bit masks of the eight knight moves: b0..b7 = (+1,+2) (-1,+2) (-2,+1) (-2,-1) (-1,-2) (+1,-2) (+2,-1) (+2,+1)
  assign w_up    = |(bus.move & 8'b1000_0111);
  assign w_dy2   = |(bus.move & 8'b0011_0011);
  assign w_right = |(bus.move & 8'b1110_0001);
  assign w_dx2   = |(bus.move & 8'b1100_1100);
  assign w_vert  = {4'b0010, w_up ? 8'h00 : 8'h7F, w_dy2 ? 4'd2 : 4'd1};
  assign w_horz  = {4'b0011, w_right ? 8'hBF : 8'h3F, w_dx2 ? 4'd2 : 4'd1};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_nxt;
      r_idx   <= w_start ? '0 : w_inc ? r_idx + 1'b1 : r_idx;
    end
  always_comb begin
    w_nxt   = r_state;
    w_start = 1'b0;
    w_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        w_start = bus.start_tour;
        w_nxt   = bus.start_tour ? VERT : IDLE;
      end
      VERT:   w_nxt = !w_valid ? IDLE : bus.clr_cmd_rdy ? HOLD_V : VERT;
      HOLD_V: w_nxt = bus.send_resp ? HORZ : HOLD_V;
      HORZ:   w_nxt = bus.clr_cmd_rdy ? HOLD_H : HORZ;
      HOLD_H: begin
        w_inc = bus.send_resp && !w_last;
        w_nxt = !bus.send_resp ? HOLD_H : w_last ? IDLE : VERT;
      end
      default: w_nxt = IDLE;
    endcase
  end
  assign bus.mv_indx      = r_idx;
  assign bus.tour_err     = r_state == VERT && !w_valid;
  assign bus.cmd          = w_idle ? bus.cmd_UART : (r_state == VERT || r_state == HOLD_V) ? w_vert : w_horz;
  assign bus.cmd_rdy      = w_idle ? bus.cmd_rdy_UART : (r_state == VERT && w_valid) || r_state == HORZ;
  assign bus.clr_UART_rdy = w_idle && bus.clr_cmd_rdy;
  assign bus.resp         = (w_idle || (r_state == HOLD_H && w_last)) ? 8'hA5 : 8'h5A;
endmodule

// File: tb/tb_tour_move_sched.sv
// tb_tour_move_sched: directed and random replay of knight's tours against a leg-level reference model
module tb_tour_move_sched;
  localparam int N = 24;
  localparam int DX[8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  localparam int DY[8] = '{2, 2, 1, -1, -2, -2, -1, 1};
  logic clk = 1'b0;
  logic rst = 1'b1;
  tour_move_sched_if #(.IDX_W(5)) bus();
  tour_move_sched #(.NUM_MOVES(N), .IDX_W(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_err = 0;
  bit m_tour, m_horz, m_wait;
  int m_idx;
  logic [7:0] tbl[N];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] leg_cmd(input logic [7:0] mv, input bit horz);
    int dx = 0;
    int dy = 0;
    for (int b = 0; b < 8; b++) if (mv[b]) begin dx = DX[b]; dy = DY[b]; end
    return horz ? {4'b0011, dx > 0 ? 8'hBF : 8'h3F, 4'(dx < 0 ? -dx : dx)}
                : {4'b0010, dy > 0 ? 8'h00 : 8'h7F, 4'(dy < 0 ? -dy : dy)};
  endfunction
  task automatic step(input logic st, input logic [7:0] mv, input logic [15:0] cu,
                      input logic cru, input logic clr, input logic sr);
    bit valid, err;
    @(negedge clk);
    bus.start_tour = st; bus.move = mv; bus.cmd_UART = cu;
    bus.cmd_rdy_UART = cru; bus.clr_cmd_rdy = clr; bus.send_resp = sr;
    #1;
    valid = $countones(mv) == 1;
    err = m_tour && !m_horz && !m_wait && !valid;
    check("mv_indx", 32'(bus.mv_indx), m_idx);
    check("tour_err", 32'(bus.tour_err), 32'(err));
    if (!m_tour) begin
      check("idle_cmd", 32'(bus.cmd), 32'(cu));
      check("idle_rdy", 32'(bus.cmd_rdy), 32'(cru));
      check("idle_clr", 32'(bus.clr_UART_rdy), 32'(clr));
      check("idle_resp", 32'(bus.resp), 32'h A5);
    end else begin
      if (!err) check("leg_cmd", 32'(bus.cmd), 32'(leg_cmd(mv, m_horz)));
      check("leg_rdy", 32'(bus.cmd_rdy), 32'(!m_wait && !err));
      check("leg_clr", 32'(bus.clr_UART_rdy), 0);
      check("leg_resp", 32'(bus.resp), (m_horz && m_wait && m_idx == N - 1) ? 32'hA5 : 32'h5A);
    end
    if (!m_tour) begin
      if (st) begin m_tour = 1; m_idx = 0; m_horz = 0; m_wait = 0; end
    end else if (err) m_tour = 0;
    else if (!m_wait) m_wait = clr;
    else if (sr) begin
      m_wait = 0;
      if (!m_horz) m_horz = 1;
      else begin
        m_horz = 0;
        if (m_idx == N - 1) m_tour = 0;
        else m_idx++;
      end
    end
  endtask
  task automatic leg(input logic [7:0] mv);
    step(0, mv, 16'h0, 0, 0, 0);
    step(0, mv, 16'h0, 0, 1, 0);
    step(0, mv, 16'h0, 0, 0, 1);
    step(0, mv, 16'h0, 0, 0, 0);
    step(0, mv, 16'h0, 0, 1, 0);
    step(0, mv, 16'h0, 0, 0, 1);
  endtask
  task automatic new_tour();
    for (int i = 0; i < N; i++) tbl[i] = 8'(1 << $urandom_range(7));
    if ($urandom_range(3) == 0) tbl[$urandom_range(N - 1)] = $urandom_range(1) ? 8'h00 : 8'h81;
  endtask
  initial begin
    logic st;
    logic [7:0] mv;
    bus.start_tour = 0; bus.move = 0; bus.cmd_UART = 0;
    bus.cmd_rdy_UART = 0; bus.clr_cmd_rdy = 0; bus.send_resp = 0;
    #2;
    check("rst_idx", 32'(bus.mv_indx), 0);
    check("rst_err", 32'(bus.tour_err), 0);
    check("rst_resp", 32'(bus.resp), 32'hA5);
    check("rst_rdy", 32'(bus.cmd_rdy), 0);
    @(negedge clk) rst = 0;
    step(0, 8'h00, 16'h2001, 1, 0, 0);
    check("t1_cmd", 32'(bus.cmd), 32'h2001);
    check("t1_rdy", 32'(bus.cmd_rdy), 1);
    step(0, 8'h00, 16'h2001, 1, 1, 0);
    check("t1_clr", 32'(bus.clr_UART_rdy), 1);
    step(1, 8'h04, 16'h0, 0, 0, 0);
    step(0, 8'h04, 16'hFFFF, 1, 0, 0);
    check("t2_vert", 32'(bus.cmd), 32'h2001);
    check("t2_rdy", 32'(bus.cmd_rdy), 1);
    step(0, 8'h04, 16'h0, 0, 1, 0);
    step(1, 8'h04, 16'h0, 0, 0, 0);
    step(0, 8'h04, 16'h0, 0, 0, 1);
    check("t2_resp", 32'(bus.resp), 32'h5A);
    step(0, 8'h04, 16'h0, 0, 0, 0);
    check("t2_horz", 32'(bus.cmd), 32'h33F2);
    step(0, 8'h04, 16'h0, 0, 1, 0);
    step(0, 8'h04, 16'h0, 0, 0, 1);
    step(0, 8'h20, 16'h0, 0, 0, 0);
    check("t3_vert", 32'(bus.cmd), 32'h27F2);
    check("t3_idx", 32'(bus.mv_indx), 1);
    step(0, 8'h20, 16'h0, 0, 1, 1);
    step(0, 8'h20, 16'h0, 0, 0, 1);
    step(0, 8'h20, 16'h0, 0, 0, 0);
    check("t3_horz", 32'(bus.cmd), 32'h3BF1);
    step(0, 8'h20, 16'h0, 0, 1, 0);
    step(0, 8'h20, 16'h0, 0, 0, 1);
    leg(8'h80);
    step(0, 8'h00, 16'h0, 0, 0, 0);
    check("t5_err", 32'(bus.tour_err), 1);
    check("t5_rdy", 32'(bus.cmd_rdy), 0);
    step(0, 8'h00, 16'h1234, 1, 0, 0);
    check("t5_idle", 32'(bus.cmd), 32'h1234);
    new_tour();
    for (int i = 0; i < N; i++) if ($countones(tbl[i]) != 1) tbl[i] = 8'h02;
    step(1, 8'h00, 16'h0, 0, 0, 0);
    for (int i = 0; i < N; i++) leg(tbl[i]);
    step(0, 8'h00, 16'hBEEF, 1, 0, 0);
    check("t4_pass", 32'(bus.cmd), 32'hBEEF);
    check("t4_idx", 32'(bus.mv_indx), N - 1);
    step(1, 8'h00, 16'h0, 0, 0, 0);
    for (int i = 0; i < 10; i++) leg(tbl[i]);
    step(0, tbl[10], 16'h0, 0, 1, 0);
    step(0, tbl[10], 16'h0, 0, 0, 1);
    @(negedge clk);
    bus.clr_cmd_rdy = 0; bus.send_resp = 0; bus.start_tour = 0; bus.cmd_rdy_UART = 0;
    #1;
    check("t6_pre_rdy", 32'(bus.cmd_rdy), 1);
    rst = 1;
    #1;
    check("t6_rdy", 32'(bus.cmd_rdy), 0);
    check("t6_idx", 32'(bus.mv_indx), 0);
    m_tour = 0; m_idx = 0;
    @(negedge clk) rst = 0;
    for (int c = 0; c < 4000; c++) begin
      st = $urandom_range(15) == 0;
      if (st && !m_tour) new_tour();
      mv = m_tour ? tbl[m_idx] : 8'($urandom);
      step(st, mv, 16'($urandom), 1'($urandom), $urandom_range(2) == 0, $urandom_range(2) == 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
